// File: rtl/shunt_fringe.sv
// Fringe endpoint of the shunt co-simulation link: registration, fringe time,
// single-slot put path towards a remote SrcDst and a per-(source, signal)
// receive mailbox read through the get path. All outputs are registered.
module shunt_fringe #(
  parameter int unsigned N_SRCDST = 4,
  parameter int unsigned N_SIG    = 4,
  parameter int unsigned DATA_W   = 1024,
  parameter int unsigned TIME_W   = 32,
  parameter int unsigned SIMID_W  = 8,
  localparam int unsigned SW = (N_SRCDST > 1) ? $clog2(N_SRCDST) : 1,
  localparam int unsigned GW = (N_SIG > 1) ? $clog2(N_SIG) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               reg_we,
  input  logic               reg_role,
  input  logic [SIMID_W-1:0] reg_simid,
  input  logic               eos_req,
  output logic [1:0]         status_o,
  output logic               role_o,
  output logic [SIMID_W-1:0] simid_o,
  output logic [TIME_W-1:0]  time_o,
  input  logic               put_req,
  input  logic [SW-1:0]      put_dst,
  input  logic [GW-1:0]      put_sig,
  input  logic               put_type,
  input  logic [DATA_W-1:0]  put_data,
  output logic               put_status,
  output logic               put_done,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [SW-1:0]      tx_dst,
  output logic [GW-1:0]      tx_sig,
  output logic               tx_type,
  output logic [DATA_W-1:0]  tx_data,
  input  logic               rx_valid,
  input  logic [SW-1:0]      rx_src,
  input  logic [GW-1:0]      rx_sig,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic               get_req,
  input  logic [SW-1:0]      get_src,
  input  logic [GW-1:0]      get_sig,
  output logic               get_success,
  output logic [DATA_W-1:0]  get_data,
  output logic               overflow_o,
  output logic               eos_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StEos    = 2'd2
  } status_e;

  status_e              status_q, status_d;
  logic                 role_q;
  logic [SIMID_W-1:0]   simid_q;
  logic [TIME_W-1:0]    time_q;
  logic                 eos_q;
  logic                 enter_eos, reg_take, active;

  logic                 tx_valid_q, put_done_q, tx_type_q;
  logic [SW-1:0]        tx_dst_q;
  logic [GW-1:0]        tx_sig_q;
  logic [DATA_W-1:0]    tx_data_q;
  logic                 put_acc;

  logic [DATA_W-1:0]    mbox_q  [N_SRCDST][N_SIG];
  logic                 valid_q [N_SRCDST][N_SIG];
  logic                 overflow_q, get_success_q;
  logic [DATA_W-1:0]    get_data_q;
  logic                 rx_in, get_in, rx_we, get_take, get_hit;

  // Status next-state: EOS has priority over registration and is terminal.
  always_comb begin
    enter_eos = (status_q != StEos) && eos_req;
    reg_take  = (status_q != StEos) && !eos_req && reg_we;
    status_d  = status_q;
    if (enter_eos) begin
      status_d = StEos;
    end else if (reg_take) begin
      status_d = StActive;
    end
  end

  assign active = (status_q == StActive);

  // Status, registration fields, EOS pulse and the free-running fringe time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= StIdle;
      role_q   <= 1'b0;
      simid_q  <= '0;
      time_q   <= '0;
      eos_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      time_q   <= time_q + TIME_W'(1);
      eos_q    <= enter_eos;
      if (reg_take) begin
        role_q  <= reg_role;
        simid_q <= reg_simid;
      end
    end
  end

  assign put_acc = active && !enter_eos && put_req && !tx_valid_q;

  // Single-slot put: the slot is busy exactly while tx_valid is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_valid_q <= 1'b0;
      put_done_q <= 1'b0;
      tx_dst_q   <= '0;
      tx_sig_q   <= '0;
      tx_type_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      put_done_q <= 1'b0;
      if (enter_eos) begin
        tx_valid_q <= 1'b0;
      end else if (tx_valid_q && tx_ready) begin
        tx_valid_q <= 1'b0;
        put_done_q <= 1'b1;
      end else if (put_acc) begin
        tx_valid_q <= 1'b1;
        tx_dst_q   <= put_dst;
        tx_sig_q   <= put_sig;
        tx_type_q  <= put_type;
        tx_data_q  <= put_data;
      end
    end
  end

  // Request qualification for the mailbox; IDs beyond the database are dropped.
  always_comb begin
    rx_in    = (32'(rx_src) < N_SRCDST) && (32'(rx_sig) < N_SIG);
    get_in   = (32'(get_src) < N_SRCDST) && (32'(get_sig) < N_SIG);
    rx_we    = (status_q != StEos) && rx_valid && rx_in;
    get_take = active && get_req && get_in;
    get_hit  = get_take && valid_q[get_src][get_sig];
  end

  // Valid flags, overflow and get response; an rx write beats a same-entry clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(N_SRCDST); s++) begin
        for (int g = 0; g < int'(N_SIG); g++) begin
          valid_q[s][g] <= 1'b0;
        end
      end
      overflow_q    <= 1'b0;
      get_success_q <= 1'b0;
      get_data_q    <= '0;
    end else begin
      get_success_q <= get_hit;
      get_data_q    <= get_hit ? mbox_q[get_src][get_sig] : '0;
      if (get_hit) begin
        valid_q[get_src][get_sig] <= 1'b0;
      end
      if (rx_we) begin
        valid_q[rx_src][rx_sig] <= 1'b1;
        if (valid_q[rx_src][rx_sig]) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // Mailbox payload storage; contents are only visible through a set valid flag.
  always_ff @(posedge clk_i) begin
    if (rx_we) begin
      mbox_q[rx_src][rx_sig] <= rx_data;
    end
  end

  assign status_o    = status_q;
  assign role_o      = role_q;
  assign simid_o     = simid_q;
  assign time_o      = time_q;
  assign eos_o       = eos_q;
  assign put_status  = tx_valid_q;
  assign put_done    = put_done_q;
  assign tx_valid    = tx_valid_q;
  assign tx_dst      = tx_dst_q;
  assign tx_sig      = tx_sig_q;
  assign tx_type     = tx_type_q;
  assign tx_data     = tx_data_q;
  assign get_success = get_success_q;
  assign get_data    = get_data_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_shunt_fringe.sv
// Self-checking bench for shunt_fringe: directed vector table, hand-written
// put/EOS sequences and a randomized phase against a behavioural model.
module tb_shunt_fringe;
  localparam int DW = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reg_we, reg_role, eos_req;
  logic [7:0]    reg_simid;
  logic [1:0]    status_o;
  logic          role_o;
  logic [7:0]    simid_o;
  logic [31:0]   time_o;
  logic          put_req, put_type, put_status, put_done;
  logic [1:0]    put_dst, put_sig;
  logic [DW-1:0] put_data;
  logic          tx_valid, tx_ready, tx_type;
  logic [1:0]    tx_dst, tx_sig;
  logic [DW-1:0] tx_data;
  logic          rx_valid;
  logic [1:0]    rx_src, rx_sig;
  logic [DW-1:0] rx_data;
  logic          get_req, get_success;
  logic [1:0]    get_src, get_sig;
  logic [DW-1:0] get_data;
  logic          overflow_o, eos_o;

  always #5 clk = ~clk;

  shunt_fringe dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_we(reg_we), .reg_role(reg_role),
    .reg_simid(reg_simid), .eos_req(eos_req), .status_o(status_o), .role_o(role_o),
    .simid_o(simid_o), .time_o(time_o), .put_req(put_req), .put_dst(put_dst),
    .put_sig(put_sig), .put_type(put_type), .put_data(put_data),
    .put_status(put_status), .put_done(put_done), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_dst(tx_dst), .tx_sig(tx_sig), .tx_type(tx_type),
    .tx_data(tx_data), .rx_valid(rx_valid), .rx_src(rx_src), .rx_sig(rx_sig),
    .rx_data(rx_data), .get_req(get_req), .get_src(get_src), .get_sig(get_sig),
    .get_success(get_success), .get_data(get_data), .overflow_o(overflow_o),
    .eos_o(eos_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the expected DUT outputs after the coming edge.
  int            m_status;  // 0 idle, 1 active, 2 eos
  logic          m_role;
  logic [7:0]    m_simid;
  logic [31:0]   m_time;
  logic          m_pend, m_done, m_eos, m_ovf, m_gs, m_type;
  logic [1:0]    m_dst, m_sig;
  logic [DW-1:0] m_data, m_gd;
  logic [DW-1:0] mb_d [4][4];
  logic          mb_v [4][4];

  typedef struct {
    logic        rv;
    logic [1:0]  rs, rg;
    logic [15:0] rd;
    logic        gv;
    logic [1:0]  gs, gg;
    logic        egs;
    logic [15:0] egd;
    logic        eovf;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_status = 0; m_role = 1'b0; m_simid = '0; m_time = '0;
    m_pend = 1'b0; m_done = 1'b0; m_eos = 1'b0; m_ovf = 1'b0; m_gs = 1'b0;
    m_type = 1'b0; m_dst = '0; m_sig = '0; m_data = '0; m_gd = '0;
    for (int s = 0; s < 4; s++)
      for (int g = 0; g < 4; g++) begin
        mb_v[s][g] = 1'b0;
        mb_d[s][g] = '0;
      end
  endtask

  // Applies the rules of one clock edge to the model, from the current inputs.
  task automatic model_step();
    bit act    = (m_status == 1);
    bit to_eos = (m_status != 2) && eos_req;
    m_gs = 1'b0;
    m_gd = '0;
    if (act && get_req && mb_v[get_src][get_sig]) begin
      m_gs = 1'b1;
      m_gd = mb_d[get_src][get_sig];
    end
    if (m_status != 2 && rx_valid && mb_v[rx_src][rx_sig]) m_ovf = 1'b1;
    if (m_gs) mb_v[get_src][get_sig] = 1'b0;
    if (m_status != 2 && rx_valid) begin
      mb_v[rx_src][rx_sig] = 1'b1;
      mb_d[rx_src][rx_sig] = rx_data;
    end
    m_done = 1'b0;
    if (to_eos) m_pend = 1'b0;
    else if (m_pend && tx_ready) begin
      m_pend = 1'b0;
      m_done = 1'b1;
    end else if (act && put_req && !m_pend) begin
      m_pend = 1'b1; m_dst = put_dst; m_sig = put_sig; m_type = put_type; m_data = put_data;
    end
    if (to_eos) m_status = 2;
    else if (reg_we && m_status != 2) begin
      m_status = 1; m_role = reg_role; m_simid = reg_simid;
    end
    m_eos  = to_eos;
    m_time = m_time + 32'd1;
  endtask

  task automatic compare_all();
    chk("status", DW'(status_o), DW'(m_status));
    chk("role", DW'(role_o), DW'(m_role));
    chk("simid", DW'(simid_o), DW'(m_simid));
    chk("time", DW'(time_o), DW'(m_time));
    chk("put_status", DW'(put_status), DW'(m_pend));
    chk("tx_valid", DW'(tx_valid), DW'(m_pend));
    chk("put_done", DW'(put_done), DW'(m_done));
    chk("eos_o", DW'(eos_o), DW'(m_eos));
    chk("overflow", DW'(overflow_o), DW'(m_ovf));
    chk("get_success", DW'(get_success), DW'(m_gs));
    chk("get_data", get_data, m_gd);
    if (m_pend) begin
      chk("tx_dst", DW'(tx_dst), DW'(m_dst));
      chk("tx_sig", DW'(tx_sig), DW'(m_sig));
      chk("tx_type", DW'(tx_type), DW'(m_type));
      chk("tx_data", tx_data, m_data);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    reg_we = 1'b0; reg_role = 1'b0; reg_simid = '0; eos_req = 1'b0;
    put_req = 1'b0; put_dst = '0; put_sig = '0; put_type = 1'b0; put_data = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_src = '0; rx_sig = '0; rx_data = '0;
    get_req = 1'b0; get_src = '0; get_sig = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd0, 2'd0, 16'h01AA, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b1, 2'd0, 2'd0, 1'b1, 16'h01AA, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b1, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 2'd0, 2'd3, 16'h01FF, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 2'd3, 16'h00AB, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b1, 2'd0, 2'd3, 1'b1, 16'h00AB, 1'b1};
    vecs[6] = '{1'b1, 2'd1, 2'd2, 16'h0333, 1'b1, 2'd1, 2'd2, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd2, 1'b1, 16'h0333, 1'b1};
    vecs[8] = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0000, 1'b1};

    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // IDLE: put and get ignored, rx still accepted.
    put_req = 1'b1; put_data = DW'(16'h0DEF); get_req = 1'b1; get_src = 2'd3; get_sig = 2'd3;
    rx_valid = 1'b1; rx_src = 2'd3; rx_sig = 2'd3; rx_data = DW'(16'h0C3C);
    cycle();
    chk("idle_tx_valid", DW'(tx_valid), '0);
    chk("idle_get", DW'(get_success), '0);
    clear_inputs();

    // Registration.
    reg_we = 1'b1; reg_role = 1'b0; reg_simid = 8'h2A;
    cycle();
    chk("reg_status", DW'(status_o), DW'(2'd1));
    chk("reg_simid", DW'(simid_o), DW'(8'h2A));
    reg_we = 1'b0;
    repeat (3) cycle();
    chk("time_at_5", DW'(time_o), DW'(32'd5));
    reg_we = 1'b1; reg_role = 1'b1; reg_simid = 8'h5C;
    cycle();
    chk("rereg_role", DW'(role_o), DW'(1'b1));
    chk("rereg_status", DW'(status_o), DW'(2'd1));
    clear_inputs();

    // Mailbox vector table.
    for (int i = 0; i < 9; i++) begin
      rx_valid = vecs[i].rv; rx_src = vecs[i].rs; rx_sig = vecs[i].rg;
      rx_data  = DW'(vecs[i].rd);
      get_req  = vecs[i].gv; get_src = vecs[i].gs; get_sig = vecs[i].gg;
      cycle();
      chk($sformatf("vec%0d_success", i), DW'(get_success), DW'(vecs[i].egs));
      chk($sformatf("vec%0d_data", i), get_data, DW'(vecs[i].egd));
      chk($sformatf("vec%0d_overflow", i), DW'(overflow_o), DW'(vecs[i].eovf));
    end
    clear_inputs();

    // Put with back-pressure; a request while busy must be dropped.
    put_req = 1'b1; put_dst = 2'd0; put_sig = 2'd1; put_type = 1'b0; put_data = DW'(16'h0155);
    cycle();
    put_dst = 2'd3; put_data = DW'(16'h0002);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_valid", k), DW'(tx_valid), DW'(1'b1));
      chk($sformatf("stall%0d_data", k), tx_data, DW'(16'h0155));
      chk($sformatf("stall%0d_dst", k), DW'(tx_dst), '0);
      chk($sformatf("stall%0d_sig", k), DW'(tx_sig), DW'(2'd1));
      if (k < 2) cycle();
      put_req = 1'b0;
    end
    tx_ready = 1'b1;
    cycle();
    chk("put_done_pulse", DW'(put_done), DW'(1'b1));
    chk("put_status_clear", DW'(put_status), '0);
    tx_ready = 1'b0;
    cycle();
    chk("no_second_xfer", DW'(tx_valid), '0);
    chk("put_done_once", DW'(put_done), '0);

    // Randomized phase against the model.
    for (int c = 0; c < 1500; c++) begin
      reg_we    = ($urandom_range(0, 49) == 0);
      reg_role  = 1'($urandom);
      reg_simid = 8'($urandom);
      put_req   = ($urandom_range(0, 2) == 0);
      put_dst   = 2'($urandom); put_sig = 2'($urandom); put_type = 1'($urandom);
      put_data  = rnd_data();
      tx_ready  = 1'($urandom);
      rx_valid  = ($urandom_range(0, 2) == 0);
      rx_src    = 2'($urandom); rx_sig = 2'($urandom);
      rx_data   = rnd_data();
      get_req   = 1'($urandom);
      get_src   = 2'($urandom); get_sig = 2'($urandom);
      cycle();
    end
    clear_inputs();

    // EOS with a put pending; eos_req beats a simultaneous reg_we.
    put_req = 1'b1; put_dst = 2'd2; put_sig = 2'd3; put_data = DW'(16'h0077);
    cycle();
    chk("pre_eos_pending", DW'(tx_valid), DW'(1'b1));
    put_req = 1'b0; eos_req = 1'b1; reg_we = 1'b1; reg_simid = ~m_simid;
    cycle();
    chk("eos_pulse", DW'(eos_o), DW'(1'b1));
    chk("eos_status", DW'(status_o), DW'(2'd2));
    chk("eos_tx_drop", DW'(tx_valid), '0);
    chk("eos_no_done", DW'(put_done), '0);
    clear_inputs();
    put_req = 1'b1; get_req = 1'b1; get_src = 2'd0; get_sig = 2'd0;
    rx_valid = 1'b1; rx_src = 2'd1; rx_sig = 2'd1; rx_data = rnd_data();
    reg_we = 1'b1; eos_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("eos%0d_pulse_once", k), DW'(eos_o), '0);
      chk($sformatf("eos%0d_tx", k), DW'(tx_valid), '0);
      chk($sformatf("eos%0d_get", k), DW'(get_success), '0);
      chk($sformatf("eos%0d_status", k), DW'(status_o), DW'(2'd2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
